// File: rtl/smix_controller.sv
// smix_controller: sequences one scrypt ROMix pass over the scratchpad around an external BlockMix core
module smix_controller #(
  parameter int N_LOG2 = 10,
  parameter int ADDR_W = 17,
  parameter int BASE_ADDR = 0,
  parameter int RD_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1023:0]     x_in,
  output logic              busy,
  output logic              done,
  output logic [1023:0]     x_out,
  output logic              bm_start,
  output logic [1023:0]     bm_in,
  input  logic              bm_done,
  input  logic [1023:0]     bm_out,
  output logic              sp_r_enable,
  output logic              sp_w_enable,
  output logic [ADDR_W-1:0] sp_addr,
  output logic [1023:0]     sp_w_data,
  input  logic [1023:0]     sp_r_data
);
  typedef enum logic [2:0] {IDLE, W_WRITE, W_MIX, R_READ, R_MIX, DONE} state_t;
  localparam int RC_W = RD_WAIT > 1 ? $clog2(RD_WAIT) : 1;
  state_t state_q, state_d;
  logic [1023:0] x_q, x_d, bm_in_q, bm_in_d, x_out_q, x_out_d;
  logic [N_LOG2-1:0] i_q, i_d, j_q, j_d;
  logic [RC_W-1:0] rd_cnt_q, rd_cnt_d;
  logic bm_start_q, bm_start_d, last_i, mixed;
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    bm_in_d = bm_in_q;
    x_out_d = x_out_q;
    i_d = i_q;
    j_d = j_q;
    rd_cnt_d = rd_cnt_q;
    bm_start_d = 1'b0;
    last_i = &i_q;
    // bm_start_q marks the first MIX cycle, where bm_done must be ignored
    mixed = bm_done && !bm_start_q;
    case (state_q)
      IDLE: if (start) begin
        x_d = x_in;
        i_d = '0;
        state_d = W_WRITE;
      end
      W_WRITE: begin
        bm_in_d = x_q;
        bm_start_d = 1'b1;
        state_d = W_MIX;
      end
      W_MIX: if (mixed) begin
        x_d = bm_out;
        i_d = i_q + 1'b1;
        j_d = last_i ? bm_out[512 +: N_LOG2] : j_q;
        state_d = last_i ? R_READ : W_WRITE;
      end
      R_READ: if (rd_cnt_q == RC_W'(RD_WAIT - 1)) begin
        bm_in_d = x_q ^ sp_r_data;
        bm_start_d = 1'b1;
        rd_cnt_d = '0;
        state_d = R_MIX;
      end else rd_cnt_d = rd_cnt_q + 1'b1;
      R_MIX: if (mixed) begin
        x_d = bm_out;
        j_d = bm_out[512 +: N_LOG2];
        i_d = i_q + 1'b1;
        x_out_d = last_i ? bm_out : x_out_q;
        state_d = last_i ? DONE : R_READ;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      x_q <= '0;
      bm_in_q <= '0;
      x_out_q <= '0;
      i_q <= '0;
      j_q <= '0;
      rd_cnt_q <= '0;
      bm_start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      bm_in_q <= bm_in_d;
      x_out_q <= x_out_d;
      i_q <= i_d;
      j_q <= j_d;
      rd_cnt_q <= rd_cnt_d;
      bm_start_q <= bm_start_d;
    end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign x_out = x_out_q;
  assign bm_start = bm_start_q;
  assign bm_in = bm_in_q;
  assign sp_w_enable = state_q == W_WRITE;
  assign sp_r_enable = state_q == R_READ;
  assign sp_w_data = sp_w_enable ? x_q : '0;
  assign sp_addr = sp_w_enable ? ADDR_W'(BASE_ADDR) + ADDR_W'(i_q) :
                   sp_r_enable ? ADDR_W'(BASE_ADDR) + ADDR_W'(j_q) : '0;
endmodule
